// File: rtl/mipsalu_mc.sv
// Registered MIPS ALU with iterative multiply/divide and HI/LO behind a valid/ready handshake.
// Define MIPSALU_DIV_EN to build the divider; otherwise DIV/DIVU complete in one cycle with ALUOut=0.
module mipsalu_mc #(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           InValid,
  output logic           Ready,
  input  logic [3:0]     ALUctl,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           ResValid,
  output logic [LEN-1:0] ALUOut,
  output logic           Zero,
  output logic           Overflow,
  output logic           DivZero,
  output logic [LEN-1:0] HI,
  output logic [LEN-1:0] LO
);
  localparam int SHW = $clog2(LEN);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t         state, state_nx;
  logic [SHW-1:0] cnt;
  logic [LEN-1:0] wh, wl, opnd;
  logic           neg_q;
`ifdef MIPSALU_DIV_EN
  logic           is_div, neg_r, dvz;
  logic [LEN:0]   dt;
  logic           dge;
  logic [LEN-1:0] drem;
`endif

  logic           accept, multi_op, signed_op;
  logic [LEN-1:0] amag, bmag;
  logic [SHW-1:0] shamt;
  logic [LEN-1:0] sum, diff, sc_res;
  logic           sc_ovf;
  logic [LEN:0]   msum;
  logic [2*LEN-1:0] prod;
  logic [LEN-1:0] fix_hi, fix_lo;

  assign Ready  = (state == IDLE);
  assign accept = InValid & Ready;
  assign shamt  = B[SHW-1:0];
  assign sum    = A + B;
  assign diff   = A - B;

`ifdef MIPSALU_DIV_EN
  assign multi_op  = (ALUctl >= 4'd11) && (ALUctl <= 4'd14);
  assign signed_op = (ALUctl == 4'd11) || (ALUctl == 4'd13);
`else
  assign multi_op  = (ALUctl == 4'd11) || (ALUctl == 4'd12);
  assign signed_op = (ALUctl == 4'd11);
`endif

  assign amag = (signed_op && A[LEN-1]) ? -A : A;
  assign bmag = (signed_op && B[LEN-1]) ? -B : B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && multi_op) state_nx = ITER;
      ITER:    if (cnt == SHW'(LEN-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUctl)
      4'd0:  sc_res = A & B;
      4'd1:  sc_res = A | B;
      4'd2: begin
        sc_res = sum;
        sc_ovf = (A[LEN-1] == B[LEN-1]) && (sum[LEN-1] != A[LEN-1]);
      end
      4'd3: begin
        sc_res = diff;
        sc_ovf = (A[LEN-1] != B[LEN-1]) && (diff[LEN-1] != A[LEN-1]);
      end
      4'd4:  sc_res = LEN'($signed(A) < $signed(B));
      4'd5:  sc_res = ~(A | B);
      4'd6:  sc_res = A ^ B;
      4'd7:  sc_res = LEN'(A < B);
      4'd8:  sc_res = A << shamt;
      4'd9:  sc_res = A >> shamt;
      4'd10: sc_res = $unsigned($signed(A) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // Multiply: wh:wl is the running product, multiplier bits leave wl from the bottom.
  assign msum = {1'b0, wh} + (wl[0] ? {1'b0, opnd} : '0);

`ifdef MIPSALU_DIV_EN
  // Restoring divide: wh is the partial remainder, wl shifts the dividend out and quotient in.
  assign dt   = {wh, wl[LEN-1]};
  assign dge  = (dt >= {1'b0, opnd});
  assign drem = dge ? (dt[LEN-1:0] - opnd) : dt[LEN-1:0];
`endif

  always_comb begin
    prod   = {wh, wl};
    if (neg_q) prod = -prod;
    fix_hi = prod[2*LEN-1:LEN];
    fix_lo = prod[LEN-1:0];
`ifdef MIPSALU_DIV_EN
    // A zero divisor leaves the dividend magnitude in wh, so the sign fix restores A in HI.
    if (is_div) begin
      fix_lo = neg_q ? -wl : wl;
      fix_hi = neg_r ? -wh : wh;
      if (dvz) fix_lo = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wh       <= '0;
      wl       <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
`ifdef MIPSALU_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
`endif
      ResValid <= 1'b0;
      ALUOut   <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      ResValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (multi_op) begin
              cnt   <= '0;
              wh    <= '0;
              neg_q <= signed_op & (A[LEN-1] ^ B[LEN-1]);
`ifdef MIPSALU_DIV_EN
              is_div <= (ALUctl == 4'd13) || (ALUctl == 4'd14);
              neg_r  <= signed_op & A[LEN-1];
              dvz    <= (B == '0);
              if ((ALUctl == 4'd13) || (ALUctl == 4'd14)) begin
                wl   <= amag;
                opnd <= bmag;
              end else begin
                wl   <= bmag;
                opnd <= amag;
              end
`else
              wl   <= bmag;
              opnd <= amag;
`endif
            end else begin
              ALUOut   <= sc_res;
              Zero     <= (sc_res == '0);
              Overflow <= sc_ovf;
              DivZero  <= 1'b0;
              ResValid <= 1'b1;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
`ifdef MIPSALU_DIV_EN
          if (is_div) begin
            wh <= drem;
            wl <= {wl[LEN-2:0], dge};
          end else begin
            wh <= msum[LEN:1];
            wl <= {msum[0], wl[LEN-1:1]};
          end
`else
          wh <= msum[LEN:1];
          wl <= {msum[0], wl[LEN-1:1]};
`endif
        end
        FIX: begin
          HI       <= fix_hi;
          LO       <= fix_lo;
          ALUOut   <= fix_lo;
          Zero     <= (fix_lo == '0);
          Overflow <= 1'b0;
`ifdef MIPSALU_DIV_EN
          DivZero  <= is_div & dvz;
`else
          DivZero  <= 1'b0;
`endif
          ResValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mipsalu_mc.sv
// Scoreboard bench for mipsalu_mc: driver pushes reference-model results, negedge monitor pops and compares.
module tb_mipsalu_mc;
  localparam int LEN = 32;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] out, hi, lo;
    logic        zero, ovf, dz;
    int          lat;
    int          issue_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        InValid = 1'b0;
  logic        Ready;
  logic [3:0]  ALUctl = '0;
  logic [31:0] A = '0, B = '0;
  logic        ResValid;
  logic [31:0] ALUOut, HI, LO;
  logic        Zero, Overflow, DivZero;

  logic        v8 = 1'b0;
  logic        rdy8;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rv8;
  logic [7:0]  out8, hi8, lo8;
  logic        z8, o8, d8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  bit junk_en = 0;
  exp_t sb[$];
  logic [31:0] model_hi = '0, model_lo = '0;
  logic [31:0] com_hi = '0, com_lo = '0, last_out = '0;
  logic        last_zero = 1'b1, last_ovf = 1'b0, last_dz = 1'b0;

  mipsalu_mc #(.LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Ready(Ready), .ALUctl(ALUctl),
    .A(A), .B(B), .ResValid(ResValid), .ALUOut(ALUOut), .Zero(Zero),
    .Overflow(Overflow), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  mipsalu_mc #(.LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .InValid(v8), .Ready(rdy8), .ALUctl(op8),
    .A(a8), .B(b8), .ResValid(rv8), .ALUOut(out8), .Zero(z8),
    .Overflow(o8), .DivZero(d8), .HI(hi8), .LO(lo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
`ifdef MIPSALU_DIV_EN
    return (op >= 4'd11) && (op <= 4'd14);
`else
    return (op == 4'd11) || (op == 4'd12);
`endif
  endfunction

  // Reference: 64-bit integer arithmetic on the architectural definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi_in, input logic [31:0] lo_in);
    exp_t e;
    logic signed [63:0] sa, sb_, s, q, r;
    logic [63:0] up;
    int sh;
    sa = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    sh = int'(b[4:0]);
    e.op = op; e.hi = hi_in; e.lo = lo_in; e.ovf = 1'b0; e.dz = 1'b0; e.out = '0;
    e.lat = 1; e.issue_cyc = 0;
    case (op)
      4'd0: e.out = a & b;
      4'd1: e.out = a | b;
      4'd2: begin s = sa + sb_; e.out = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: begin s = sa - sb_; e.out = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4: e.out = (sa < sb_) ? 32'd1 : 32'd0;
      4'd5: e.out = ~(a | b);
      4'd6: e.out = a ^ b;
      4'd7: e.out = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd8: e.out = a << sh;
      4'd9: e.out = a >> sh;
      4'd10: begin s = sa >>> sh; e.out = s[31:0]; end
      4'd11: begin s = sa * sb_; e.hi = s[63:32]; e.lo = s[31:0]; end
      4'd12: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
`ifdef MIPSALU_DIV_EN
      4'd13, 4'd14: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a; e.dz = 1'b1;
        end else if (op == 4'd13) begin
          q = sa / sb_; r = sa % sb_; e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
`endif
      default: e.out = '0;
    endcase
    if (is_multi(op)) begin
      e.out = e.lo;
      e.lat = LEN + 2;
    end
    e.zero = (e.out == 0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int guard = 0;
    @(negedge clk);
    while (!Ready && guard < 100) begin
      if (junk_en && $urandom_range(0, 1) == 1) begin
        InValid = 1'b1; ALUctl = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
      end else begin
        InValid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    if (!Ready) begin
      chk("ready_timeout", 64'(Ready), 64'd1);
      InValid = 1'b0;
      return;
    end
    InValid = 1'b1; ALUctl = op; A = a; B = b;
    e = model(op, a, b, model_hi, model_lo);
    e.issue_cyc = cyc;
    model_hi = e.hi; model_lo = e.lo;
    sb.push_back(e);
    @(posedge clk);
    #1 InValid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      com_hi = '0; com_lo = '0; last_out = '0;
      last_zero = 1'b1; last_ovf = 1'b0; last_dz = 1'b0;
      busy_run = 0;
    end else begin
      if (ResValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resvalid", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("aluout", 64'(ALUOut), 64'(e.out));
          chk("zero", 64'(Zero), 64'(e.zero));
          chk("overflow", 64'(Overflow), 64'(e.ovf));
          chk("divzero", 64'(DivZero), 64'(e.dz));
          chk("latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
          com_hi = e.hi; com_lo = e.lo;
          last_out = e.out; last_zero = e.zero; last_ovf = e.ovf; last_dz = e.dz;
        end
      end else begin
        chk("hold_outputs", {ALUOut, Zero, Overflow, DivZero}, {last_out, last_zero, last_ovf, last_dz});
      end
      chk("hilo", {HI, LO}, {com_hi, com_lo});
      if (!Ready) begin
        busy_run++;
      end else if (busy_run != 0) begin
        chk("ready_low_cycles", 64'(busy_run), 64'(LEN + 1));
        busy_run = 0;
      end
    end
  end

  initial begin
    int guard;
    int rv_seen;
    int c0;
    logic [3:0] op;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_resvalid", 64'(ResValid), 64'd0);
    chk("rst_aluout", 64'(ALUOut), 64'd0);
    chk("rst_flags", {Zero, Overflow, DivZero}, 64'b100);
    chk("rst_hilo", {HI, LO}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    issue(4'd3, 32'd5, 32'd5);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);

    junk_en = 1;
    issue(4'd11, 32'hFFFF_FFFD, 32'd7);
    issue(4'd13, 32'hFFFF_FFF9, 32'd2);
    issue(4'd14, 32'd9, 32'd0);
    issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd10, 32'h8000_0000, 32'd31);
    issue(4'd9, 32'h8000_0000, 32'd31);
    issue(4'd8, 32'd1, 32'h21);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = 4'($urandom_range(0, 15));
      issue(op, pick(), pick());
    end
    junk_en = 0;

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 64'(sb.size()), 64'd0);

    // Abort a MULTU in flight
    issue(4'd12, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(Ready), 64'd1);
    chk("abort_hilo", {HI, LO}, 64'd0);
    chk("abort_resvalid", 64'(ResValid), 64'd0);
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ResValid) rv_seen++;
    end
    chk("abort_no_resvalid", 64'(rv_seen), 64'd0);

    // LEN=8 instance
    @(negedge clk);
    op8 = 4'd12; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 v8 = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!rv8 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("len8_resvalid", 64'(rv8), 64'd1);
    chk("len8_latency", 64'(cyc - c0), 64'd10);
    chk("len8_hilo", {hi8, lo8}, {8'hFE, 8'h01});
    chk("len8_aluout", 64'(out8), 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
